// File: rtl/heap_alloc.sv
// heap_alloc: bump-pointer cell allocator. On each accepted request it writes
// one three-word cell (header, car, cdr) to memory and advances free_ptr.
// Ports: clk, rst (sync, active-high); alloc_req/header/car/cdr request side;
// clear rewinds free_ptr; alloc_ready/done/addr/full status; mem_we/addr/sel/
// data/ack memory write port; free_ptr next cell to hand out.
module heap_alloc #(
   parameter logic [15:0] HEAP_BASE  = 16'h0100,
   parameter logic [15:0] HEAP_LIMIT = 16'h0FFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alloc_req,
   input  logic [14:0] alloc_header,
   input  logic [15:0] alloc_car,
   input  logic [15:0] alloc_cdr,
   input  logic        clear,
   output logic        alloc_ready,
   output logic        alloc_done,
   output logic [15:0] alloc_addr,
   output logic        alloc_full,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [1:0]  mem_sel,
   output logic [15:0] mem_data,
   input  logic        mem_ack,
   output logic [15:0] free_ptr
);

   typedef enum logic [2:0] {
      IDLE,
      W_HDR,
      W_CAR,
      W_CDR,
      DONE,
      FULL
   } state_t;

   state_t      state;
   logic [14:0] hdr;
   logic [15:0] car;
   logic [15:0] cdr;
   logic [15:0] target;

   // clear has priority over a request in the same IDLE cycle
   assign alloc_ready = (state == IDLE) && !clear;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         free_ptr   <= HEAP_BASE;
         alloc_addr <= 16'h0000;
         alloc_done <= 1'b0;
         alloc_full <= 1'b0;
         hdr        <= '0;
         car        <= '0;
         cdr        <= '0;
         target     <= '0;
      end else begin
         alloc_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (clear) begin
                  free_ptr <= HEAP_BASE;
               end else if (alloc_req) begin
                  hdr    <= alloc_header;
                  car    <= alloc_car;
                  cdr    <= alloc_cdr;
                  target <= free_ptr;
                  // exhaustion is sticky: only rst leaves FULL
                  if (free_ptr > HEAP_LIMIT) begin
                     state      <= FULL;
                     alloc_full <= 1'b1;
                  end else begin
                     state <= W_HDR;
                  end
               end
            end
            W_HDR: if (mem_ack) state <= W_CAR;
            W_CAR: if (mem_ack) state <= W_CDR;
            W_CDR: if (mem_ack) state <= DONE;
            DONE: begin
               alloc_done <= 1'b1;
               alloc_addr <= target;
               free_ptr   <= target + 16'd1;
               state      <= IDLE;
            end
            FULL: state <= FULL;
            default: state <= IDLE;
         endcase
      end
   end

   // write port is a pure decode of the registered state and latched cell
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = 16'h0000;
      mem_sel  = 2'd0;
      mem_data = 16'h0000;
      unique case (state)
         W_HDR: begin
            mem_we   = 1'b1;
            mem_addr = target;
            mem_sel  = 2'd0;
            mem_data = {1'b0, hdr};
         end
         W_CAR: begin
            mem_we   = 1'b1;
            mem_addr = target;
            mem_sel  = 2'd1;
            mem_data = car;
         end
         W_CDR: begin
            mem_we   = 1'b1;
            mem_addr = target;
            mem_sel  = 2'd2;
            mem_data = cdr;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: doc/heap_alloc.md
HEAP_ALLOC -- requirements
Module: heap_alloc

Interface
REQ-001 SHALL have parameter HEAP_BASE, default 16'h0100, first allocatable cell address.
REQ-002 SHALL have parameter HEAP_LIMIT, default 16'h0FFF, last allocatable cell address (inclusive).
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port alloc_req  input  1  request to allocate and write one cell.
REQ-006 SHALL have port alloc_header  input  15  cell type tag, excluding the GC bit.
REQ-007 SHALL have port alloc_car  input  16  car word.
REQ-008 SHALL have port alloc_cdr  input  16  cdr word.
REQ-009 SHALL have port clear  input  1  rewind free pointer to HEAP_BASE.
REQ-010 SHALL have port alloc_ready  output  1  high when a request is accepted this cycle.
REQ-011 SHALL have port alloc_done  output  1  one-cycle pulse when the cell is fully written.
REQ-012 SHALL have port alloc_addr  output  16  address of the allocated cell; valid from alloc_done until the next acceptance.
REQ-013 SHALL have port alloc_full  output  1  sticky heap-exhausted flag.
REQ-014 SHALL have port mem_we  output  1  memory write strobe.
REQ-015 SHALL have port mem_addr  output  16  cell address being written.
REQ-016 SHALL have port mem_sel  output  2  field select: 0 header, 1 car, 2 cdr.
REQ-017 SHALL have port mem_data  output  16  write data.
REQ-018 SHALL have port mem_ack  input  1  memory accepted the current beat.
REQ-019 SHALL have port free_ptr  output  16  next cell address to be allocated.

Function
REQ-020 SHALL implement states IDLE, W_HDR, W_CAR, W_CDR, DONE, FULL.
REQ-021 SHALL drive alloc_ready = (state == IDLE) && !clear, combinationally.
REQ-022 SHALL accept a request on the cycle alloc_req && alloc_ready, and on that edge latch header/car/cdr and capture free_ptr as the target address.
REQ-023 SHALL, on acceptance with free_ptr <= HEAP_LIMIT, go to W_HDR; with free_ptr > HEAP_LIMIT, go to FULL and issue no write.
REQ-024 SHALL, in W_HDR/W_CAR/W_CDR, hold mem_we=1, mem_addr=target, mem_sel=0/1/2, with mem_data={1'b0,header}, car, and cdr respectively.
REQ-025 SHALL keep all write outputs stable while mem_ack=0, and advance W_HDR->W_CAR->W_CDR->DONE on each cycle with mem_ack=1.
REQ-026 SHALL, in DONE, pulse alloc_done for exactly one cycle, set alloc_addr=target and free_ptr=target+1, then return to IDLE.
REQ-027 SHALL give a latency of 4 cycles from acceptance edge to alloc_done high when mem_ack is held at 1; each ack-low cycle adds 1.
REQ-028 SHALL drive mem_we=0, mem_sel=0, and mem_data=0 outside the write states.
REQ-029 SHALL ignore alloc_req outside IDLE, with no queuing.
REQ-030 SHALL, on clear in IDLE, set free_ptr=HEAP_BASE; clear in any other state has no effect; clear and alloc_req in the same IDLE cycle -> clear wins and the request is not accepted.
REQ-031 SHALL, in FULL, hold alloc_full=1 and alloc_ready=0 and ignore clear; only rst exits FULL.
REQ-032 SHALL permit allocation of cell HEAP_LIMIT itself; free_ptr then becomes HEAP_LIMIT+1, and the next request enters FULL.
REQ-033 SHALL compute free_ptr increments in 16 bits with no wrap check beyond REQ-023 (HEAP_LIMIT < 16'hFFFF).

Reset
REQ-034 SHALL, on rst, set state=IDLE, free_ptr=HEAP_BASE, alloc_addr=0 (NIL), alloc_done=0, alloc_full=0, mem_we=0, with rst taking priority over all inputs.
REQ-035 SHALL, on rst mid-write, abandon the cell with no further beats, leave free_ptr=HEAP_BASE, and raise no alloc_done.

Verification
REQ-036 SHALL verify: after reset, req with header=2 (CONS), car=0x0105, cdr=0x0000, and ack tied high -> beats (0x0100,0,0x0002),(0x0100,1,0x0105),(0x0100,2,0x0000); alloc_done at +4 cycles; alloc_addr=0x0100; free_ptr=0x0101.
REQ-037 SHALL verify: the same request with mem_ack low 3 cycles during W_CAR -> car beat held stable 4 cycles; done at +7; data unchanged.
REQ-038 SHALL verify: HEAP_LIMIT=0x0101 and three requests -> cells 0x0100 and 0x0101 written; the third produces no mem_we, with alloc_full=1 and alloc_ready=0 until rst.
REQ-039 SHALL verify: alloc_req during W_HDR with different data -> ignored; the written cell keeps the original data.
REQ-040 SHALL verify: after two allocations (free_ptr=0x0102), clear+alloc_req together -> free_ptr=0x0100 with no acceptance; the next request writes 0x0100.
REQ-041 SHALL verify: rst asserted in W_CAR -> next cycle mem_we=0, free_ptr=0x0100, no alloc_done.
